// File: rtl/memory_access_sequencer_pkg.sv
// Shared core types: memory controller modes, funct3 access codes, sequencer states.
package JZJCoreFTypes;

  typedef enum logic [1:0] {
    MEM_NOP           = 2'd0,
    MEM_LOAD          = 2'd1,
    MEM_STORE_PRELOAD = 2'd2,
    MEM_STORE         = 2'd3
  } MemoryMode_t;

  typedef logic [2:0] Funct3_t;

  localparam Funct3_t FUNCT3_B  = 3'b000;
  localparam Funct3_t FUNCT3_H  = 3'b001;
  localparam Funct3_t FUNCT3_W  = 3'b010;
  localparam Funct3_t FUNCT3_BU = 3'b100;
  localparam Funct3_t FUNCT3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    LOAD_WAIT = 3'd2,
    PRELOAD   = 3'd3,
    STORE     = 3'd4,
    RESPOND   = 3'd5,
    FAULT     = 3'd6
  } MemSeqState_t;

  function automatic logic is_legal_load(input Funct3_t f3);
    return (f3 == FUNCT3_B) || (f3 == FUNCT3_H) || (f3 == FUNCT3_W) ||
           (f3 == FUNCT3_BU) || (f3 == FUNCT3_HU);
  endfunction

  function automatic logic is_legal_store(input Funct3_t f3);
    return (f3 == FUNCT3_B) || (f3 == FUNCT3_H) || (f3 == FUNCT3_W);
  endfunction

endpackage

// File: rtl/memory_access_sequencer_load_formatter.sv
// Selects and extends the addressed byte/halfword/word of a raw memory word.
module load_formatter
  import JZJCoreFTypes::*;
(
  input  Funct3_t     funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    // Halfwords are only legal on even offsets; the controller flags odd ones.
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      FUNCT3_B:  result = {{24{byte_sel[7]}}, byte_sel};
      FUNCT3_BU: result = {24'h000000, byte_sel};
      FUNCT3_H:  result = {{16{half_sel[15]}}, half_sel};
      FUNCT3_HU: result = {16'h0000, half_sel};
      FUNCT3_W:  result = word;
      default:   result = 32'h00000000;
    endcase
  end

endmodule

// File: rtl/memory_access_sequencer.sv
// Load/store sequencer between control unit and memory controller.
// Optional macro MEMSEQ_FAST_WORD_STORE_EN: aligned sw skips the PRELOAD cycle.
module memory_access_sequencer
  import JZJCoreFTypes::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqIsStore,
  input  Funct3_t     funct3,
  input  logic [1:0]  accessOffset,
  output MemoryMode_t memoryMode,
  input  logic        memoryUnalignedAccess,
  input  logic [31:0] memoryOutput,
  output logic [31:0] rdData,
  output logic        rdWriteEnable,
  output logic        done,
  output logic        fault
);

  MemSeqState_t state_reg, state_next;
  logic         is_store_reg;
  Funct3_t      funct3_reg;
  logic [1:0]   offset_reg;
  logic [31:0]  rd_data_reg;
  logic [31:0]  formatted;
  logic         accept;

  assign accept = (state_reg == IDLE) && reqValid;

  load_formatter u_load_formatter (
    .funct3 (funct3_reg),
    .offset (offset_reg),
    .word   (memoryOutput),
    .result (formatted)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      is_store_reg <= 1'b0;
      funct3_reg   <= '0;
      offset_reg   <= '0;
      rd_data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        is_store_reg <= reqIsStore;
        funct3_reg   <= funct3;
        offset_reg   <= accessOffset;
      end
      if (state_reg == LOAD_WAIT) rd_data_reg <= formatted;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (reqValid) begin
          if (reqIsStore) begin
            if (!is_legal_store(funct3)) state_next = FAULT;
`ifdef MEMSEQ_FAST_WORD_STORE_EN
            else if ((funct3 == FUNCT3_W) && (accessOffset == 2'b00)) state_next = STORE;
`endif
            else state_next = PRELOAD;
          end else begin
            state_next = is_legal_load(funct3) ? LOAD : FAULT;
          end
        end
      end
      LOAD:      state_next = memoryUnalignedAccess ? FAULT : LOAD_WAIT;
      LOAD_WAIT: state_next = RESPOND;
      PRELOAD:   state_next = memoryUnalignedAccess ? FAULT : STORE;
      STORE:     state_next = RESPOND;
      RESPOND:   state_next = IDLE;
      FAULT:     state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    memoryMode = MEM_NOP;
    case (state_reg)
      LOAD, LOAD_WAIT: memoryMode = MEM_LOAD;
      PRELOAD:         memoryMode = MEM_STORE_PRELOAD;
      STORE:           memoryMode = MEM_STORE;
      default:         memoryMode = MEM_NOP;
    endcase
  end

  assign reqReady      = (state_reg == IDLE);
  assign done          = (state_reg == RESPOND) || (state_reg == FAULT);
  assign fault         = (state_reg == FAULT);
  assign rdWriteEnable = (state_reg == RESPOND) && !is_store_reg;
  assign rdData        = rd_data_reg;

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Self-checking bench: directed cases plus random transactions against a cycle-count model.
module tb_memory_access_sequencer;
  import JZJCoreFTypes::*;

  logic        clock;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic        reqIsStore;
  Funct3_t     funct3;
  logic [1:0]  accessOffset;
  MemoryMode_t memoryMode;
  logic        memoryUnalignedAccess;
  logic [31:0] memoryOutput;
  logic [31:0] rdData;
  logic        rdWriteEnable;
  logic        done;
  logic        fault;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rd_model = 32'h0;

  memory_access_sequencer dut (
    .clock                 (clock),
    .reset                 (reset),
    .reqValid              (reqValid),
    .reqReady              (reqReady),
    .reqIsStore            (reqIsStore),
    .funct3                (funct3),
    .accessOffset          (accessOffset),
    .memoryMode            (memoryMode),
    .memoryUnalignedAccess (memoryUnalignedAccess),
    .memoryOutput          (memoryOutput),
    .rdData                (rdData),
    .rdWriteEnable         (rdWriteEnable),
    .done                  (done),
    .fault                 (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: expected mode per cycle, completion cycle, fault and load result.
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] w, input logic force_unal);
    MemoryMode_t modes[4];
    int          n;
    logic        exp_fault;
    logic        unal;
    logic        legal;
    logic [31:0] bsel, hsel, fmt;
    logic [31:0] rd_exp;
    string       name;

    unal = force_unal;
    if (f3[1:0] == 2'b10 && off != 2'b00) unal = 1'b1;
    if (f3[1:0] == 2'b01 && off[0]) unal = 1'b1;

    bsel = (w >> (8 * off)) & 32'hFF;
    hsel = (w >> (off[1] ? 16 : 0)) & 32'hFFFF;
    case (f3)
      3'b000:  fmt = (bsel >= 32'h80) ? (bsel | 32'hFFFFFF00) : bsel;
      3'b100:  fmt = bsel;
      3'b001:  fmt = (hsel >= 32'h8000) ? (hsel | 32'hFFFF0000) : hsel;
      3'b101:  fmt = hsel;
      default: fmt = w;
    endcase

    legal = st ? (f3 <= 3'b010) : (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111);
    for (int i = 0; i < 4; i++) modes[i] = MEM_NOP;
    exp_fault = 1'b0;
    if (!legal) begin
      n = 1; exp_fault = 1'b1;
    end else if (!st) begin
      modes[1] = MEM_LOAD;
      if (unal) begin n = 2; exp_fault = 1'b1; end
      else begin modes[2] = MEM_LOAD; n = 3; end
    end else begin
`ifdef MEMSEQ_FAST_WORD_STORE_EN
      if (f3 == 3'b010 && off == 2'b00) begin
        modes[1] = MEM_STORE; n = 2;
      end else
`endif
      begin
        modes[1] = MEM_STORE_PRELOAD;
        if (unal) begin n = 2; exp_fault = 1'b1; end
        else begin modes[2] = MEM_STORE; n = 3; end
      end
    end

    name = $sformatf("%s f3=%0d off=%0d", st ? "st" : "ld", f3, off);
    check({name, " ready"}, {31'b0, reqReady}, 32'd1);
    check({name, " mode0"}, {30'b0, memoryMode}, {30'b0, MEM_NOP});

    reqValid = 1'b1; reqIsStore = st; funct3 = f3; accessOffset = off;
    memoryOutput = w; memoryUnalignedAccess = unal;

    for (int k = 1; k <= n; k++) begin
      step();
      // Inputs other than the memory response may wander after accept.
      reqValid     = (k < n) ? 1'($urandom_range(0, 1)) : 1'b0;
      reqIsStore   = 1'($urandom_range(0, 1));
      funct3       = 3'($urandom_range(0, 7));
      accessOffset = 2'($urandom_range(0, 3));
      rd_exp = (k == n && !st && !exp_fault) ? fmt : rd_model;
      check($sformatf("%s mode%0d", name, k), {30'b0, memoryMode}, {30'b0, modes[k]});
      check($sformatf("%s done%0d", name, k), {31'b0, done}, {31'b0, (k == n)});
      check($sformatf("%s fault%0d", name, k), {31'b0, fault}, {31'b0, (k == n) && exp_fault});
      check($sformatf("%s rdwe%0d", name, k), {31'b0, rdWriteEnable},
            {31'b0, (k == n) && !st && !exp_fault});
      check($sformatf("%s rddata%0d", name, k), rdData, rd_exp);
    end
    if (!st && !exp_fault) rd_model = fmt;
    $display("txn %s word=%h unal=%0d cycles=%0d fault=%0d rdData=%h", name, w, unal, n,
             exp_fault, rdData);
    step();
  endtask

  initial begin
    reset = 1'b0; reqValid = 1'b0; reqIsStore = 1'b0; funct3 = 3'b000;
    accessOffset = 2'b00; memoryUnalignedAccess = 1'b0; memoryOutput = 32'h0;
    step();
    check("reset ready", {31'b0, reqReady}, 32'd1);
    check("reset mode", {30'b0, memoryMode}, {30'b0, MEM_NOP});
    check("reset rddata", rdData, 32'h0);
    check("reset done", {29'b0, done, fault, rdWriteEnable}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    step();

    run_txn(1'b0, 3'b000, 2'd3, 32'h80FFFFFF, 1'b0);
    check("lb result", rdData, 32'hFFFFFF80);
    run_txn(1'b0, 3'b101, 2'd2, 32'hBEEF1234, 1'b0);
    check("lhu result", rdData, 32'h0000BEEF);
    run_txn(1'b1, 3'b000, 2'd1, 32'h12345678, 1'b0);
    run_txn(1'b0, 3'b010, 2'd0, 32'hCAFEF00D, 1'b1);
    run_txn(1'b0, 3'b011, 2'd0, 32'h11111111, 1'b0);
    run_txn(1'b1, 3'b100, 2'd0, 32'h22222222, 1'b0);
    run_txn(1'b1, 3'b010, 2'd0, 32'h33333333, 1'b0);
    run_txn(1'b1, 3'b001, 2'd1, 32'h44444444, 1'b0);

    // Reset during STORE: outputs drop immediately, no retry afterwards.
    reqValid = 1'b1; reqIsStore = 1'b1; funct3 = 3'b000; accessOffset = 2'd2;
    memoryUnalignedAccess = 1'b0;
    step();
    reqValid = 1'b0;
`ifndef MEMSEQ_FAST_WORD_STORE_EN
    check("rst preload", {30'b0, memoryMode}, {30'b0, MEM_STORE_PRELOAD});
`endif
    step();
    check("rst store", {30'b0, memoryMode}, {30'b0, MEM_STORE});
    #1 reset = 1'b0;
    #1;
    check("rst mid mode", {30'b0, memoryMode}, {30'b0, MEM_NOP});
    check("rst mid ready", {31'b0, reqReady}, 32'd1);
    check("rst mid rddata", rdData, 32'h0);
    check("rst mid pulses", {29'b0, done, fault, rdWriteEnable}, 32'h0);
    #1 reset = 1'b1;
    step();
    check("rst after mode", {30'b0, memoryMode}, {30'b0, MEM_NOP});
    check("rst after done", {31'b0, done}, 32'd0);
    rd_model = 32'h0;
    $display("txn reset during store: mode=%0d ready=%0d rdData=%h", memoryMode, reqReady, rdData);

    for (int t = 0; t < 80; t++) begin
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
              $urandom, ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access_sequencer.md
MEMORY_ACCESS_SEQUENCER -- requirements
Module: memory_access_sequencer

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have port reqValid, input, 1, control unit requests a load/store this cycle.
REQ-004 SHALL have port reqReady, output, 1, sequencer accepts a request this cycle.
REQ-005 SHALL have port reqIsStore, input, 1, 1 = store, 0 = load; sampled on accept.
REQ-006 SHALL have port funct3, input, Funct3_t, access width/signedness; sampled on accept.
REQ-007 SHALL have port accessOffset, input, 2, byte offset (low 2 bits of effective address); sampled on accept.
REQ-008 SHALL have port memoryMode, output, MemoryMode_t, mode driven to the memory controller.
REQ-009 SHALL have port memoryUnalignedAccess, input, 1, alignment error flag from the memory controller.
REQ-010 SHALL have port memoryOutput, input, 32, raw word from the memory controller; byte lane k at bits [8k+7:8k].
REQ-011 SHALL have port rdData, output, 32, formatted load result.
REQ-012 SHALL have port rdWriteEnable, output, 1, one-cycle pulse: write rdData to the register file.
REQ-013 SHALL have port done, output, 1, one-cycle pulse: access finished (success or fault).
REQ-014 SHALL have port fault, output, 1, one-cycle pulse coincident with done: access aborted.

Function
REQ-015 SHALL implement states IDLE, LOAD, LOAD_WAIT, PRELOAD, STORE, RESPOND, FAULT; memoryMode SHALL be decoded combinationally from state only.
REQ-016 SHALL drive memoryMode: IDLE/RESPOND/FAULT -> NOP; LOAD/LOAD_WAIT -> LOAD; PRELOAD -> STORE_PRELOAD; STORE -> STORE.
REQ-017 SHALL assert reqReady only in IDLE; reqValid in any other state is ignored.
REQ-018 On accept: illegal funct3 (loads: 011,110,111; stores: anything but 000,001,010) -> FAULT with no memory access; legal load -> LOAD; legal store -> PRELOAD.
REQ-019 LOAD: if memoryUnalignedAccess=1 -> FAULT, else -> LOAD_WAIT.
REQ-020 LOAD_WAIT: register the formatted memoryOutput into rdData -> RESPOND.
REQ-021 PRELOAD: if memoryUnalignedAccess=1 -> FAULT (no STORE issued), else -> STORE.
REQ-022 STORE: exactly one cycle -> RESPOND.
REQ-023 RESPOND: done=1; rdWriteEnable=1 only for loads; -> IDLE.
REQ-024 FAULT: done=1, fault=1, rdWriteEnable=0, rdData unchanged; -> IDLE.
REQ-025 Latency, accept cycle = 0: load done at cycle 3; store done at cycle 3; alignment fault done at cycle 2; illegal-funct3 fault at cycle 1.
REQ-026 Load format: 000 sign-extended byte at offset; 100 zero-extended byte; 001/101 sign-/zero-extended halfword at bits [15:0] (offset 0) or [31:16] (offset 2); 010 full word.
REQ-027 Upstream SHALL hold rs1, rs2 and immediates stable from accept until done; the sequencer does not check this.

Reset
REQ-028 Assertion SHALL immediately force state IDLE, memoryMode NOP, reqReady 1, rdData 0, rdWriteEnable 0, done 0, fault 0, including mid-access; an interrupted STORE cycle is not retried.

Configuration
REQ-029 Macro MEMSEQ_FAST_WORD_STORE_EN: when defined, a store with funct3 010 and accessOffset 00 SHALL go IDLE -> STORE directly (done at cycle 2); when undefined, all stores pass through PRELOAD.

Structure
REQ-030 MemoryMode_t and Funct3_t SHALL come from JZJCoreFTypes; a MemSeqState_t enum and the funct3 width constants SHALL be added to that package.
REQ-031 Load formatting SHALL live in one combinational sub-module load_formatter (inputs funct3, offset, word; output 32-bit result).

Verification
REQ-032 Load lb, offset 3, memoryOutput 0x80FFFFFF -> rdData 0xFFFFFF80, rdWriteEnable and done pulsed at cycle 3.
REQ-033 Load lhu, offset 2, memoryOutput 0xBEEF1234 -> rdData 0x0000BEEF at cycle 3.
REQ-034 Store sb -> memoryMode sequence NOP, STORE_PRELOAD, STORE, NOP; done at cycle 3, rdWriteEnable 0.
REQ-035 Load lw with memoryUnalignedAccess=1 in LOAD -> done=fault=1 at cycle 2, memoryMode never STORE, rdData unchanged.
REQ-036 reset pulsed low during STORE -> memoryMode NOP in the same cycle, all outputs at reset values; with MEMSEQ_FAST_WORD_STORE_EN, sw at offset 0 -> done at cycle 2.
